s1_fft_stage_ctrl: RTL and testbench

- Sequencer for stage 1 of the 32-point radix-2 SDF FFT.
- Accepts a streaming complex sample handshake and tracks the sample index inside the frame.
- Drives butterfly mode and the delay-line enable for the stage-1 butterfly/delay line.
- Drives the 5-bit twiddle index for the stage-1 twiddle multiplier, with output valid/frame markers, and drains the delay line on request with zero-insertion cycles.

---
 rtl/s1_fft_stage_ctrl.sv | 134 +++++++++++++
 tb/tb_s1_fft_stage_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/s1_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// s1_fft_stage_ctrl
//
// Sequencer for stage 1 of a 32-point radix-2 single-delay-feedback FFT.
// Tracks the sample index inside a frame from a valid/ready input handshake.
// From that index it drives the butterfly mode, the delay-line shift enable
// and the twiddle index for the stage-1 multiplier. It also drives the output
// valid and frame-start markers. On request it drains the delay line, using
// 16 zero-insertion cycles after the current frame.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   in_valid        upstream sample valid
//   in_ready        sample accepted when in_valid && in_ready at a rising edge
//   flush           single-cycle request: drain the pipeline after this frame
//   bf_mode         0 = load delay line / pass delayed difference,
//                   1 = butterfly (sum out, difference into delay line)
//   dl_en           delay-line shift enable
//   zero_ins        datapath substitutes 0+j0 for the input sample
//   mult_counter    twiddle index for the stage-1 multiplier
//                   (0..15 twiddle multiply, 16..31 bypass)
//   out_valid       stage-1 output sample valid
//   out_frame_start first output sample of a frame
//   busy            sequencer is not idle
//
// Every output except in_ready and busy is registered. Each one describes the
// sample accepted at the previous edge, so it lines up with the datapath
// input register.
// -----------------------------------------------------------------------------
module s1_fft_stage_ctrl #(
    parameter int N  = 32,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic          bf_mode,
    output logic          dl_en,
    output logic          zero_ins,
    output logic [CW-1:0] mult_counter,
    output logic          out_valid,
    output logic          out_frame_start,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [CW-1:0] HALF_M1 = CW'(N / 2 - 1);
    localparam logic [CW-1:0] HALF    = CW'(N / 2);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          flush_pend;
    logic          acc;

    // During FLUSH the sequencer generates its own zero samples every cycle.
    // Upstream samples are refused while that happens.
    assign in_ready = (state != FLUSH);
    assign acc      = (state == FLUSH) || (in_valid && in_ready);
    assign busy     = (state != IDLE);

    // NOTE: all state and output registers use non-blocking assignments.
    // Later assignments in this block (cnt clear, flush_pend clear on FLUSH
    // entry) intentionally override the earlier defaults for the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            flush_pend      <= 1'b0;
            bf_mode         <= 1'b0;
            dl_en           <= 1'b0;
            zero_ins        <= 1'b0;
            mult_counter    <= '0;
            out_valid       <= 1'b0;
            out_frame_start <= 1'b0;
        end else begin
            // Per-sample strobes are asserted only in the cycle after an
            // accepted sample.
            dl_en           <= acc;
            zero_ins        <= acc && (state == FLUSH);
            // First-frame samples 0..15 only fill the delay line, so no
            // output exists for them yet.
            out_valid       <= acc && ((state == RUN) || (state == FLUSH));
            out_frame_start <= acc && ((state == RUN) || (state == FLUSH))
                               && (cnt == HALF);

            // Mode and twiddle index hold their last value across stalls.
            if (acc) begin
                bf_mode      <= cnt[CW-1];
                mult_counter <= cnt;
                cnt          <= cnt + 1'b1;
            end

            // A flush request seen mid-frame is remembered until frame end.
            if (flush && ((state == FILL) || (state == RUN)))
                flush_pend <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (acc)
                        state <= FILL;
                end
                FILL: begin
                    if (acc && (cnt == HALF_M1))
                        state <= RUN;
                end
                RUN: begin
                    if (acc && (cnt == LAST) && (flush_pend || flush)) begin
                        state      <= FLUSH;
                        flush_pend <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Half a frame of zeros empties the N/2-deep delay line.
                    if (cnt == HALF_M1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s1_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_s1_fft_stage_ctrl
//
// Directed bench for s1_fft_stage_ctrl. Inputs change on the falling edge.
// Outputs are sampled 1 time unit after the rising edge. Expected values come
// from the sample index that each directed sequence feeds in.
// -----------------------------------------------------------------------------
module tb_s1_fft_stage_ctrl;

    localparam int N  = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          flush;
    logic          in_ready;
    logic          bf_mode;
    logic          dl_en;
    logic          zero_ins;
    logic [CW-1:0] mult_counter;
    logic          out_valid;
    logic          out_frame_start;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    s1_fft_stage_ctrl #(.N(N), .CW(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .bf_mode         (bf_mode),
        .dl_en           (dl_en),
        .zero_ins        (zero_ins),
        .mult_counter    (mult_counter),
        .out_valid       (out_valid),
        .out_frame_start (out_frame_start),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One clock: drive inputs on the falling edge, then sample just after the
    // rising edge.
    task automatic step(input logic v, input logic f, input logic r);
        @(negedge clk);
        in_valid = v;
        flush    = f;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    // Expected outputs in the cycle after a sample with index c is accepted.
    task automatic chk_acc(input string tag, input int c, input bit ov,
                           input bit zi);
        check($sformatf("%s c=%0d dl_en", tag, c), 32'(dl_en), 1);
        check($sformatf("%s c=%0d mult", tag, c), 32'(mult_counter), c);
        check($sformatf("%s c=%0d bf_mode", tag, c), 32'(bf_mode),
              (c >= 16) ? 1 : 0);
        check($sformatf("%s c=%0d out_valid", tag, c), 32'(out_valid),
              ov ? 1 : 0);
        check($sformatf("%s c=%0d frame_start", tag, c),
              32'(out_frame_start), (ov && c == 16) ? 1 : 0);
        check($sformatf("%s c=%0d zero_ins", tag, c), 32'(zero_ins),
              zi ? 1 : 0);
    endtask

    // Expected outputs in a cycle after a stall; last_c is the previous index.
    task automatic chk_hold(input string tag, input int last_c);
        check($sformatf("%s hold dl_en", tag), 32'(dl_en), 0);
        check($sformatf("%s hold out_valid", tag), 32'(out_valid), 0);
        check($sformatf("%s hold frame_start", tag), 32'(out_frame_start), 0);
        check($sformatf("%s hold zero_ins", tag), 32'(zero_ins), 0);
        check($sformatf("%s hold mult", tag), 32'(mult_counter), last_c);
        check($sformatf("%s hold bf_mode", tag), 32'(bf_mode),
              (last_c >= 16) ? 1 : 0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " dl_en"}, 32'(dl_en), 0);
        check({tag, " out_valid"}, 32'(out_valid), 0);
        check({tag, " frame_start"}, 32'(out_frame_start), 0);
        check({tag, " zero_ins"}, 32'(zero_ins), 0);
        check({tag, " mult"}, 32'(mult_counter), 0);
        check({tag, " bf_mode"}, 32'(bf_mode), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " in_ready"}, 32'(in_ready), 1);
    endtask

    // 16 drain cycles that follow the acceptance of c=31 with a flush. The
    // upstream keeps in_valid high to show that it is ignored.
    task automatic chk_flush(input string tag);
        check({tag, " enter in_ready"}, 32'(in_ready), 0);
        check({tag, " enter busy"}, 32'(busy), 1);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_acc(tag, k, 1'b1, 1'b1);
            check($sformatf("%s k=%0d in_ready", tag, k), 32'(in_ready),
                  (k == 15) ? 1 : 0);
            check($sformatf("%s k=%0d busy", tag, k), 32'(busy),
                  (k == 15) ? 0 : 1);
        end
        step(1'b0, 1'b0, 1'b0);
        check({tag, " after out_valid"}, 32'(out_valid), 0);
        check({tag, " after busy"}, 32'(busy), 0);
        check({tag, " after in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_reset("reset");

        // Two back-to-back frames: first half of frame 1 is silent, then
        // continuous output; frame start only at global samples 16 and 48.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_acc("frames", i % 32, i >= 16, 1'b0);
        end

        // Alternating valid through a full RUN frame.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_acc("toggle", i, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            chk_hold($sformatf("toggle c=%0d", i), i);
            check($sformatf("toggle c=%0d busy", i), 32'(busy), 1);
        end

        // Flush pulsed with c=20; honoured at the end of the frame.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i == 20), 1'b0);
            chk_acc("flush20", i, 1'b1, 1'b0);
        end
        chk_flush("flush20 drain");

        // Flush in IDLE is ignored and must not arm a later drain.
        step(1'b0, 1'b1, 1'b0);
        check("idle flush busy", 32'(busy), 0);
        check("idle flush in_ready", 32'(in_ready), 1);
        check("idle flush out_valid", 32'(out_valid), 0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk_acc("noflush", i, i >= 16, 1'b0);
        end
        check("noflush still running", 32'(in_ready), 1);

        // Flush on the same edge as the acceptance of c=31.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i == 31), 1'b0);
            chk_acc("flush31", i, 1'b1, 1'b0);
        end
        chk_flush("flush31 drain");

        // Reset at c=10 of RUN, with in_valid also high: reset wins.
        for (int i = 0; i < 43; i++)
            step(1'b1, 1'b0, 1'b0);
        check("pre-rst run mult", 32'(mult_counter), 10);
        step(1'b1, 1'b0, 1'b1);
        chk_reset("rst run");
        step(1'b0, 1'b0, 1'b0);
        check("rst run release out_valid", 32'(out_valid), 0);
        step(1'b1, 1'b0, 1'b0);
        chk_acc("restart1", 0, 1'b0, 1'b0);
        check("restart1 busy", 32'(busy), 1);

        // Finish that frame with a flush, then reset on the 4th drain cycle.
        for (int i = 1; i < 32; i++)
            step(1'b1, (i == 31), 1'b0);
        check("pre-flush ready", 32'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0);
            chk_acc("mid drain", k, 1'b1, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        chk_reset("rst flush");
        step(1'b1, 1'b0, 1'b0);
        chk_acc("restart2", 0, 1'b0, 1'b0);
        check("restart2 busy", 32'(busy), 1);
        check("restart2 in_ready", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
